operand_forward_unit: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the 5-stage pipeline. It tracks destination tags of the instructions in EXE and MEM and computes per-operand forward selects in ID, registering them into EXE. In EXE it muxes each operand between the MEM result, the WB write-back bus and the register-file value. It generalises the single-operand, purely combinational forwarding mux to NPORT operands, adds load-use stall generation, flush and hold handling, and a stall counter.

---
 rtl/operand_forward_unit.sv | 138 +++++++++++++
 tb/tb_operand_forward_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_forward_unit.sv
// Operand forwarding and load-use hazard unit for the 5-stage pipeline.
// Tracks EXE/MEM destination tags, registers per-port selects into EXE.
module operand_forward_unit #(
  parameter int W        = 32,
  parameter int AW       = 5,
  parameter int NPORT    = 2,
  parameter int ZERO_REG = 1,
  parameter int CNTW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_we,
  input  logic                 id_load,
  input  logic [NPORT*AW-1:0]  id_rs,
  input  logic [NPORT-1:0]     id_rs_used,
  input  logic                 flush,
  input  logic                 pipe_hold,
  input  logic [W-1:0]         mem_result,
  input  logic [W-1:0]         wb_busw,
  input  logic [NPORT*W-1:0]   ex_bus,
  output logic                 stall,
  output logic [NPORT*2-1:0]   ex_sel,
  output logic [NPORT*W-1:0]   ex_data,
  output logic [CNTW-1:0]      stall_count
);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          we;
    logic          load;
  } ex_tag_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          we;
  } mem_tag_t;

  localparam logic [1:0] SEL_MEM = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_RF  = 2'b10;
  localparam logic [NPORT*2-1:0] SEL_ALL_RF = {NPORT{SEL_RF}};

  ex_tag_t             ex_tag_q, ex_tag_d;
  mem_tag_t            mem_tag_q, mem_tag_d;
  logic [NPORT*2-1:0]  ex_sel_q, ex_sel_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic [NPORT-1:0]    ex_hit;
  logic [NPORT-1:0]    mem_hit;
  logic [NPORT*2-1:0]  sel_id;

  function automatic logic hit(
    input logic          v,
    input logic          we,
    input logic [AW-1:0] rd,
    input logic [AW-1:0] r
  );
    return v & we & (r == rd) & ~((ZERO_REG != 0) & (r == '0));
  endfunction

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [AW-1:0] rs;
    logic [W-1:0]  d;

    assign rs = id_rs[p*AW +: AW];

    assign ex_hit[p] = hit(ex_tag_q.v, ex_tag_q.we,
                           ex_tag_q.rd, rs);
    assign mem_hit[p] = hit(mem_tag_q.v, mem_tag_q.we,
                            mem_tag_q.rd, rs);

    // a load in EXE has no data yet; fall back to the older producer
    assign sel_id[p*2 +: 2] =
      (ex_hit[p] & ~ex_tag_q.load) ? SEL_MEM :
      mem_hit[p]                   ? SEL_WB  :
                                     SEL_RF;

    always_comb begin
      unique case (ex_sel_q[p*2 +: 2])
        SEL_MEM: d = mem_result;
        SEL_WB:  d = wb_busw;
        default: d = ex_bus[p*W +: W];
      endcase
    end

    assign ex_data[p*W +: W] = d;
  end

  assign stall = id_valid & ~flush & ex_tag_q.load
               & |(ex_hit & id_rs_used);

  always_comb begin
    ex_tag_d  = ex_tag_q;
    mem_tag_d = mem_tag_q;
    ex_sel_d  = ex_sel_q;
    cnt_d     = cnt_q;
    if (!pipe_hold) begin
      mem_tag_d.v  = ex_tag_q.v;
      mem_tag_d.rd = ex_tag_q.rd;
      mem_tag_d.we = ex_tag_q.we;
      if (flush || stall) begin
        ex_tag_d = '0;
        ex_sel_d = SEL_ALL_RF;
        if (stall && !(&cnt_q)) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end else begin
        ex_tag_d.v    = id_valid;
        ex_tag_d.rd   = id_rd;
        ex_tag_d.we   = id_we;
        ex_tag_d.load = id_load;
        ex_sel_d      = sel_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag_q  <= '0;
      mem_tag_q <= '0;
      ex_sel_q  <= SEL_ALL_RF;
      cnt_q     <= '0;
    end else begin
      ex_tag_q  <= ex_tag_d;
      mem_tag_q <= mem_tag_d;
      ex_sel_q  <= ex_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_sel      = ex_sel_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Randomized scoreboard bench for operand_forward_unit.
// Two instances (ZERO_REG=1/0) share stimulus; a reference model predicts both.
module tb_operand_forward_unit;

  localparam int W  = 64;
  localparam int AW = 5;
  localparam int NP = 3;
  localparam int CA = 6;
  localparam int CB = 16;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_we, id_load, flush, pipe_hold;
  logic [AW-1:0]    id_rd;
  logic [NP*AW-1:0] id_rs;
  logic [NP-1:0]    id_rs_used;
  logic [W-1:0]     mem_result, wb_busw;
  logic [NP*W-1:0]  ex_bus;

  logic             stall_a, stall_b;
  logic [NP*2-1:0]  sel_a, sel_b;
  logic [NP*W-1:0]  data_a, data_b;
  logic [CA-1:0]    cnt_a;
  logic [CB-1:0]    cnt_b;

  operand_forward_unit #(
    .W(W), .AW(AW), .NPORT(NP), .ZERO_REG(1), .CNTW(CA)
  ) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd),
    .id_we(id_we), .id_load(id_load), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .flush(flush), .pipe_hold(pipe_hold),
    .mem_result(mem_result), .wb_busw(wb_busw), .ex_bus(ex_bus),
    .stall(stall_a), .ex_sel(sel_a), .ex_data(data_a),
    .stall_count(cnt_a)
  );

  operand_forward_unit #(
    .W(W), .AW(AW), .NPORT(NP), .ZERO_REG(0), .CNTW(CB)
  ) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd),
    .id_we(id_we), .id_load(id_load), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .flush(flush), .pipe_hold(pipe_hold),
    .mem_result(mem_result), .wb_busw(wb_busw), .ex_bus(ex_bus),
    .stall(stall_b), .ex_sel(sel_b), .ex_data(data_b),
    .stall_count(cnt_b)
  );

  always #5 clk = ~clk;

  // reference model: the instructions in flight, oldest last
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } instr_t;

  typedef struct packed {
    logic            stall;
    logic [NP*2-1:0] sel;
    logic [NP*W-1:0] data;
    logic [15:0]     cnt;
  } exp_t;

  instr_t m_ex [2];
  instr_t m_mem [2];
  int     m_src [2][NP];
  int     m_cnt [2];
  int     cmax [2] = '{63, 65535};
  int     zr [2]   = '{1, 0};

  exp_t qa[$];
  exp_t qb[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic int rs_of(int p);
    logic [NP*AW-1:0] v;
    v = id_rs;
    return int'(v[p*AW +: AW]);
  endfunction

  function automatic bit writes(instr_t t, int r, int k);
    return t.v && t.we && t.rd == r && !(zr[k] != 0 && r == 0);
  endfunction

  // newest in-flight writer whose value exists: 0=MEM, 1=WB, 2=regfile
  function automatic int source_of(int k, int r);
    instr_t fl [2];
    fl[0] = m_ex[k];
    fl[1] = m_mem[k];
    for (int a = 0; a < 2; a++) begin
      if (writes(fl[a], r, k) && !(a == 0 && fl[a].ld)) return a;
    end
    return 2;
  endfunction

  function automatic bit load_use(int k);
    bit s;
    s = 0;
    for (int p = 0; p < NP; p++) begin
      if (id_rs_used[p] && m_ex[k].ld && writes(m_ex[k], rs_of(p), k))
        s = 1;
    end
    return id_valid && !flush && s;
  endfunction

  function automatic logic [W-1:0] pick(int src, int p);
    logic [NP*W-1:0] b;
    b = ex_bus;
    case (src)
      0: return mem_result;
      1: return wb_busw;
      default: return b[p*W +: W];
    endcase
  endfunction

  task automatic reset_model(int k);
    m_ex[k]  = '{1'b0, 0, 1'b0, 1'b0};
    m_mem[k] = '{1'b0, 0, 1'b0, 1'b0};
    for (int p = 0; p < NP; p++) m_src[k][p] = 2;
    m_cnt[k] = 0;
  endtask

  task automatic step_model(int k, output exp_t e);
    bit st;
    int nsrc [NP];
    if (rst) reset_model(k);
    st = load_use(k);
    e.stall = st;
    for (int p = 0; p < NP; p++) begin
      e.sel[p*2 +: 2]  = 2'(m_src[k][p]);
      e.data[p*W +: W] = pick(m_src[k][p], p);
      nsrc[p] = source_of(k, rs_of(p));
    end
    e.cnt = 16'(m_cnt[k]);
    if (!rst && !pipe_hold) begin
      m_mem[k] = m_ex[k];
      if (flush || st) begin
        m_ex[k] = '{1'b0, 0, 1'b0, 1'b0};
        for (int p = 0; p < NP; p++) m_src[k][p] = 2;
        if (st && m_cnt[k] < cmax[k]) m_cnt[k]++;
      end else begin
        m_ex[k] = '{id_valid, int'(id_rd), id_we, id_load};
        for (int p = 0; p < NP; p++) m_src[k][p] = nsrc[p];
      end
    end
  endtask

  task automatic check(string nm, logic [NP*W-1:0] act,
                       logic [NP*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t ea, eb;
    if (qa.size() > 0 && qb.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      check("stall_a", (NP*W)'(stall_a), (NP*W)'(ea.stall));
      check("sel_a",   (NP*W)'(sel_a),   (NP*W)'(ea.sel));
      check("data_a",  data_a,           ea.data);
      check("cnt_a",   (NP*W)'(cnt_a),   (NP*W)'(ea.cnt));
      check("stall_b", (NP*W)'(stall_b), (NP*W)'(eb.stall));
      check("sel_b",   (NP*W)'(sel_b),   (NP*W)'(eb.sel));
      check("data_b",  data_b,           eb.data);
      check("cnt_b",   (NP*W)'(cnt_b),   (NP*W)'(eb.cnt));
    end
  end

  task automatic drive(int cyc);
    rst       = (cyc < 3) || (cyc >= 1500 && cyc < 1502);
    id_valid  = ($urandom_range(0, 99) < 85);
    id_we     = ($urandom_range(0, 99) < 80);
    id_load   = ($urandom_range(0, 99) < 30);
    flush     = ($urandom_range(0, 99) < 8);
    pipe_hold = ($urandom_range(0, 99) < 10);
    id_rd     = AW'($urandom_range(0, 3));
    for (int p = 0; p < NP; p++) begin
      id_rs[p*AW +: AW] = AW'($urandom_range(0, 3));
      id_rs_used[p]     = ($urandom_range(0, 3) != 0);
    end
    mem_result = {$urandom, $urandom};
    wb_busw    = {$urandom, $urandom};
    for (int i = 0; i < NP*2; i++) ex_bus[i*32 +: 32] = $urandom;
  endtask

  initial begin
    exp_t e;
    int guard;
    rst = 1'b1;
    drive(0);
    reset_model(0);
    reset_model(1);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      step_model(0, e);
      qa.push_back(e);
      step_model(1, e);
      qb.push_back(e);
    end
    guard = 0;
    while ((qa.size() > 0 || qb.size() > 0) && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      miscompares++;
      $display("FAIL drain got=%0d expected=0", qa.size() + qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
